leds_pattern_gen: RTL and testbench

//  Multi-channel LED driver. It generalises the single fixed-period blinker to NUM_LEDS

---
 rtl/leds_pkg.sv | 19 +
 rtl/leds_pattern_gen_channel.sv | 141 ++++++++++++++
 rtl/leds_pattern_gen.sv | 53 +++++
 tb/tb_leds_pattern_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Purpose: shared mode codes and burst FSM encoding for the LED pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package leds_pkg;

  // Channel modes as written on cfg_mode.
  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_ON    = 2'd1;
  localparam logic [1:0] LED_BLINK = 2'd2;
  localparam logic [1:0] LED_BURST = 2'd3;

  // Burst sequencer state. IDLE is also the resting state for non-burst modes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } burst_state_t;

endpackage

// File: rtl/leds_pattern_gen_channel.sv
// Purpose: one LED channel: config regs, half-period counter, pulse counter, burst FSM.
// Latency: a config write is visible on led/done/busy one cycle after the write edge.
// Backpressure: none; a write is always accepted and aborts any burst in progress.
module leds_pattern_gen_channel
  import leds_pkg::*;
#(
  parameter int               CNT_W      = 28,
  parameter int               BURST_W    = 8,
  parameter logic [CNT_W-1:0] RST_PERIOD = 28'd40_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_mode,
  input  logic [CNT_W-1:0]   wr_period,
  input  logic [BURST_W-1:0] wr_count,
  output logic               led,
  output logic               done,
  output logic               busy
);

  logic [1:0]         mode_q,   mode_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [BURST_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BURST_W-1:0] pulse_q,  pulse_d;
  burst_state_t       state_q,  state_d;
  logic               led_q,    led_d;
  logic               done_q,   done_d;

  logic               half_end;
  logic [BURST_W-1:0] pulse_inc;

  assign half_end  = (cnt_q == period_q);
  assign pulse_inc = pulse_q + 1'b1;

  // Next-state: a write reloads everything and restarts; otherwise run the current mode.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    state_d  = state_q;
    led_d    = led_q;
    done_d   = 1'b0;

    if (wr_en) begin
      mode_d   = wr_mode;
      period_d = wr_period;
      count_d  = wr_count;
      cnt_d    = '0;
      pulse_d  = '0;
      led_d    = (wr_mode == LED_ON);
      state_d  = ST_IDLE;
      if (wr_mode == LED_BURST) begin
        if (wr_count == '0) begin
          // Empty burst: finish straight away so the requester still sees a done pulse.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else begin
      case (mode_q)
        LED_OFF: begin
          led_d = 1'b0;
          cnt_d = '0;
        end
        LED_ON: begin
          led_d = 1'b1;
          cnt_d = '0;
        end
        LED_BLINK: begin
          if (half_end) begin
            cnt_d = '0;
            led_d = ~led_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LED_BURST: begin
          if (state_q == ST_RUN) begin
            if (half_end) begin
              cnt_d = '0;
              led_d = ~led_q;
              // A falling edge completes one pulse; the last one ends the burst.
              if (led_q) begin
                if (pulse_inc == count_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  led_d   = 1'b0;
                end else begin
                  pulse_d = pulse_inc;
                end
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            led_d = 1'b0;
            cnt_d = '0;
          end
        end
        default: begin
          led_d = 1'b0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State register; reset puts the channel back to OFF with the boot-time period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= LED_OFF;
      period_q <= RST_PERIOD;
      count_q  <= '0;
      cnt_q    <= '0;
      pulse_q  <= '0;
      state_q  <= ST_IDLE;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign led  = led_q;
  assign done = done_q;
  assign busy = (state_q == ST_RUN);

endmodule

// File: rtl/leds_pattern_gen.sv
// Purpose: NUM_LEDS independent LED channels (OFF/ON/BLINK/BURST) with a shared config port.
// Latency: one cycle from config write edge to led_out/burst_done/busy.
// Backpressure: none; writes to a channel index >= NUM_LEDS are dropped.
module leds_pattern_gen
  import leds_pkg::*;
#(
  parameter int               NUM_LEDS   = 4,
  parameter int               CNT_W      = 28,
  parameter int               BURST_W    = 8,
  parameter logic [CNT_W-1:0] RST_PERIOD = 28'd40_000_000,
  parameter int               IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [BURST_W-1:0]  cfg_count,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] burst_done,
  output logic [NUM_LEDS-1:0] busy
);

  logic [NUM_LEDS-1:0] ch_we;

  // Index decode: only existing channels can match, so out-of-range writes vanish.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      ch_we[i] = cfg_we && (cfg_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    leds_pattern_gen_channel #(
      .CNT_W      (CNT_W),
      .BURST_W    (BURST_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ch_we[g]),
      .wr_mode   (cfg_mode),
      .wr_period (cfg_period),
      .wr_count  (cfg_count),
      .led       (led_out[g]),
      .done      (burst_done[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_leds_pattern_gen.sv
// Purpose: directed self-checking bench for leds_pattern_gen (5 channels, 3-bit index).
// Latency: expectations are per cycle, sampled on the falling edge.
// Backpressure: n/a.
module tb_leds_pattern_gen;

  localparam int               NUM_LEDS = 5;
  localparam int               CNT_W    = 28;
  localparam int               BURST_W  = 8;
  localparam int               IDX_W    = 3;
  localparam logic [CNT_W-1:0] RST_P    = 28'd40_000_000;

  logic                clk;
  logic                rst;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [1:0]          cfg_mode;
  logic [CNT_W-1:0]    cfg_period;
  logic [BURST_W-1:0]  cfg_count;
  logic [NUM_LEDS-1:0] led_out;
  logic [NUM_LEDS-1:0] burst_done;
  logic [NUM_LEDS-1:0] busy;

  int checks = 0;
  int errors = 0;

  leds_pattern_gen #(
    .NUM_LEDS   (NUM_LEDS),
    .CNT_W      (CNT_W),
    .BURST_W    (BURST_W),
    .RST_PERIOD (RST_P),
    .IDX_W      (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .led_out    (led_out),
    .burst_done (burst_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Caller sits at a falling edge; the write is taken on the next rising edge and the
  // task returns at the falling edge after it (first cycle showing the write's effect).
  task automatic cfg_write(input int idx, input logic [1:0] mode,
                           input int period, input int count);
    cfg_we     = 1'b1;
    cfg_idx    = IDX_W'(idx);
    cfg_mode   = mode;
    cfg_period = CNT_W'(period);
    cfg_count  = BURST_W'(count);
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  logic [11:0] pat_led;
  logic [11:0] pat_busy;
  logic [11:0] pat_done;
  logic [5:0]  pat_mid;

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_mode   = 2'd0;
    cfg_period = '0;
    cfg_count  = '0;

    // 1. reset, then ch0 BLINK period 3
    repeat (5) @(negedge clk);
    check("rst_led_held", 32'(led_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    cfg_write(0, 2'd2, 3, 0);
    for (int j = 1; j <= 12; j++) begin
      check($sformatf("blink3_c%0d", j), 32'(led_out[0]), 32'(((j - 1) / 4) % 2));
      @(negedge clk);
    end

    // 2. ch1 BURST period 1 count 2: 0011 0011 in RUN, then DONE with one-cycle done
    pat_led  = 12'b0000_1100_1100;
    pat_busy = 12'b0000_1111_1111;
    pat_done = 12'b0001_0000_0000;
    cfg_write(1, 2'd3, 1, 2);
    for (int j = 1; j <= 12; j++) begin
      check($sformatf("burst_led_c%0d", j),  32'(led_out[1]),    32'(pat_led[j-1]));
      check($sformatf("burst_busy_c%0d", j), 32'(busy[1]),       32'(pat_busy[j-1]));
      check($sformatf("burst_done_c%0d", j), 32'(burst_done[1]), 32'(pat_done[j-1]));
      @(negedge clk);
    end

    // 3. ch2 BLINK period 0, then ON, then OFF
    cfg_write(2, 2'd2, 0, 0);
    for (int j = 1; j <= 6; j++) begin
      check($sformatf("blink0_c%0d", j), 32'(led_out[2]), 32'((j - 1) % 2));
      @(negedge clk);
    end
    cfg_write(2, 2'd1, 5, 0);
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("on_c%0d", j), 32'(led_out[2]), 32'd1);
      @(negedge clk);
    end
    cfg_write(2, 2'd0, 5, 0);
    check("off_c1", 32'(led_out[2]), 32'd0);
    @(negedge clk);
    check("off_c2", 32'(led_out[2]), 32'd0);

    // 4. out-of-range indices are dropped; count=0 burst finishes at once
    cfg_write(5, 2'd1, 0, 0);
    cfg_write(7, 2'd3, 0, 4);
    for (int j = 1; j <= 3; j++) begin
      check($sformatf("oor_led_c%0d", j),  32'(led_out[4:1]),    32'd0);
      check($sformatf("oor_busy_c%0d", j), 32'(busy[4:1]),       32'd0);
      check($sformatf("oor_done_c%0d", j), 32'(burst_done[4:1]), 32'd0);
      @(negedge clk);
    end
    cfg_write(3, 2'd3, 2, 0);
    for (int j = 1; j <= 5; j++) begin
      check($sformatf("cnt0_done_c%0d", j), 32'(burst_done[3]), 32'(j == 1));
      check($sformatf("cnt0_led_c%0d", j),  32'(led_out[3]),    32'd0);
      check($sformatf("cnt0_busy_c%0d", j), 32'(busy[3]),       32'd0);
      @(negedge clk);
    end

    // 5a. ch1 rewritten as BLINK period 2 while high mid-burst
    pat_mid = 6'b111000;
    cfg_write(1, 2'd3, 1, 2);
    repeat (2) @(negedge clk);
    check("mid_led_before", 32'(led_out[1]), 32'd1);
    cfg_write(1, 2'd2, 2, 0);
    for (int j = 1; j <= 6; j++) begin
      check($sformatf("mid_led_c%0d", j),  32'(led_out[1]),    32'(pat_mid[j-1]));
      check($sformatf("mid_done_c%0d", j), 32'(burst_done[1]), 32'd0);
      check($sformatf("mid_busy_c%0d", j), 32'(busy[1]),       32'd0);
      @(negedge clk);
    end

    // 5b. rewrite lands on the edge of the final falling edge
    cfg_write(1, 2'd3, 1, 2);
    for (int j = 1; j <= 7; j++) begin
      check($sformatf("fin_busy_c%0d", j), 32'(busy[1]), 32'd1);
      @(negedge clk);
    end
    cfg_write(1, 2'd2, 1, 0);
    for (int j = 1; j <= 5; j++) begin
      check($sformatf("fin_led_c%0d", j),  32'(led_out[1]),    32'(((j - 1) / 2) % 2));
      check($sformatf("fin_done_c%0d", j), 32'(burst_done[1]), 32'd0);
      @(negedge clk);
    end

    // 6. async reset mid-burst while ch0 blinks
    cfg_write(1, 2'd3, 3, 3);
    repeat (5) @(negedge clk);
    check("pre_rst_led1", 32'(led_out[1]), 32'd1);
    check("pre_rst_busy1", 32'(busy[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_led", 32'(led_out), 32'd0);
    check("async_done", 32'(burst_done), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_period_ch0", 32'(dut.g_ch[0].u_ch.period_q), 32'(RST_P));
    check("rst_period_ch1", 32'(dut.g_ch[1].u_ch.period_q), 32'(RST_P));
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_led_c%0d", j),  32'(led_out),    32'd0);
      check($sformatf("post_rst_done_c%0d", j), 32'(burst_done), 32'd0);
      check($sformatf("post_rst_busy_c%0d", j), 32'(busy),       32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
